// File: rtl/regfile_multiport.sv
// Parametrised 2-read/1-write register file with a valid/ready register dump engine.
// Define REGFILE_WR_BYPASS_EN to forward same-cycle legal writes to the read ports.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 1 << ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr1,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr2,
  output logic [DATA_WIDTH-1:0] o_rd_data1,
  output logic [DATA_WIDTH-1:0] o_rd_data2,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_busy,
  output logic                  o_dump_done
);

  localparam logic [ADDR_WIDTH:0]   NUM_REGS_EXT = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR     = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dump_state_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  dump_state_t           state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  wr_legal;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < NUM_REGS_EXT);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Stored contents only; out-of-range and the hard-wired zero register read as 0.
  function automatic logic [DATA_WIDTH-1:0] read_raw(input logic [ADDR_WIDTH-1:0] a);
    if (!in_range(a) || is_zero_reg(a))
      return '0;
    else
      return regs[a];
  endfunction

  assign wr_legal = i_wr_en && in_range(i_wr_addr) && !is_zero_reg(i_wr_addr);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_legal) begin
      regs[i_wr_addr] <= i_wr_data;
    end
  end

`ifdef REGFILE_WR_BYPASS_EN
  // Dropped writes never reach the bypass because wr_legal already excludes them.
  always_comb begin
    o_rd_data1 = read_raw(i_rd_addr1);
    o_rd_data2 = read_raw(i_rd_addr2);
    if (wr_legal && (i_rd_addr1 == i_wr_addr))
      o_rd_data1 = i_wr_data;
    if (wr_legal && (i_rd_addr2 == i_wr_addr))
      o_rd_data2 = i_wr_data;
  end
`else
  always_comb begin
    o_rd_data1 = read_raw(i_rd_addr1);
    o_rd_data2 = read_raw(i_rd_addr2);
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      o_dump_valid <= 1'b0;
      o_dump_busy  <= 1'b0;
      o_dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_dump_start) begin
            state        <= RUN;
            ptr          <= '0;
            o_dump_valid <= 1'b1;
            o_dump_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (i_dump_ready) begin
            if (ptr == LAST_PTR) begin
              state        <= DONE;
              o_dump_valid <= 1'b0;
              o_dump_done  <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          o_dump_busy <= 1'b0;
          o_dump_done <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          o_dump_valid <= 1'b0;
          o_dump_busy  <= 1'b0;
          o_dump_done  <= 1'b0;
        end
      endcase
    end
  end

  // Address and data are forced to 0 outside RUN; data follows the array live.
  always_comb begin
    o_dump_addr = '0;
    o_dump_data = '0;
    if (state == RUN) begin
      o_dump_addr = ptr;
      o_dump_data = read_raw(ptr);
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed, table-driven bench for regfile_multiport (default 32x32, zero register on).
module tb_regfile_multiport;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [4:0]  i_rd_addr1 = '0;
  logic [4:0]  i_rd_addr2 = '0;
  logic [31:0] o_rd_data1;
  logic [31:0] o_rd_data2;
  logic        i_wr_en = 1'b0;
  logic [4:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_dump_start = 1'b0;
  logic        i_dump_ready = 1'b0;
  logic        o_dump_valid;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_busy;
  logic        o_dump_done;

  int checks = 0;
  int failures = 0;

  regfile_multiport dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_rd_addr1   (i_rd_addr1),
    .i_rd_addr2   (i_rd_addr2),
    .o_rd_data1   (o_rd_data1),
    .o_rd_data2   (o_rd_data2),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] b1;
    logic [31:0] b2;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_wr_en    = v.wr_en;
    i_wr_addr  = v.wr_addr;
    i_wr_data  = v.wr_data;
    i_rd_addr1 = v.ra1;
    i_rd_addr2 = v.ra2;
  endtask

  // Drives one dump; ready is constant 1 or toggles 1/0, optionally re-pulsing start mid-dump.
  task automatic run_dump(input bit toggle, input int start_pulse_cycle, input int budget,
                          output int done_cycle, output int beats);
    int idx;
    idx = 0;
    beats = 0;
    done_cycle = -1;
    @(negedge i_clk);
    i_dump_start = 1'b1;
    i_dump_ready = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge i_clk);
      i_dump_start = (k == start_pulse_cycle);
      i_dump_ready = toggle ? (k % 2 == 1) : 1'b1;
      #1;
      if (o_dump_done) begin
        done_cycle = k;
        checkOutput("done_valid_low", 32'(o_dump_valid), 32'd0);
        checkOutput("done_busy_high", 32'(o_dump_busy), 32'd1);
        break;
      end
      checkOutput("dump_valid", 32'(o_dump_valid), 32'd1);
      checkOutput("dump_busy", 32'(o_dump_busy), 32'd1);
      checkOutput("dump_addr", 32'(o_dump_addr), 32'(idx));
      checkOutput("dump_data", o_dump_data, 32'(idx * 3));
      if (i_dump_ready && o_dump_valid) begin
        idx++;
        beats++;
      end
    end
    i_dump_start = 1'b0;
    @(negedge i_clk);
    #1;
    checkOutput("after_done_done_low", 32'(o_dump_done), 32'd0);
    checkOutput("after_done_busy_low", 32'(o_dump_busy), 32'd0);
  endtask

  initial begin
    int done_cycle;
    int beats;
    int done_seen;
    bit found;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd7,  32'h11,       5'd0,  5'd7,  32'h0,        32'h0,        32'h0,        32'h11};
    vecs[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,  32'h11,       32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 5'd9,  32'hFFFF,     5'd9,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd9,  5'd31, 32'h0,        32'h0,        32'h0,        32'hCAFEF00D};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd9,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0};
    vecs[9] = '{1'b1, 5'd1,  32'h1,        5'd1,  5'd0,  32'h0,        32'h0,        32'h1,        32'h0};

    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("reset_busy", 32'(o_dump_busy), 32'd0);
    checkOutput("reset_valid", 32'(o_dump_valid), 32'd0);
    checkOutput("reset_done", 32'(o_dump_done), 32'd0);
    i_reset_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      @(negedge i_clk);
      i_rd_addr1 = 5'(a);
      i_rd_addr2 = 5'(31 - a);
      #1;
      checkOutput("reset_read1", o_rd_data1, 32'h0);
      checkOutput("reset_read2", o_rd_data2, 32'h0);
    end

    for (int v = 0; v < 10; v++) begin
      @(negedge i_clk);
      applyStimulus(vecs[v]);
      #1;
      checkOutput($sformatf("vec%0d_rd1", v), o_rd_data1, BYPASS ? vecs[v].b1 : vecs[v].e1);
      checkOutput($sformatf("vec%0d_rd2", v), o_rd_data2, BYPASS ? vecs[v].b2 : vecs[v].e2);
    end

    for (int i = 0; i < 32; i++) begin
      @(negedge i_clk);
      i_wr_en   = 1'b1;
      i_wr_addr = 5'(i);
      i_wr_data = 32'(i * 3);
    end
    @(negedge i_clk);
    i_wr_en    = 1'b0;
    i_rd_addr1 = 5'd10;
    i_rd_addr2 = 5'd0;
    #1;
    checkOutput("load_rd10", o_rd_data1, 32'd30);
    checkOutput("load_rd0", o_rd_data2, 32'd0);

    $display("[TB] dump with ready tied high");
    run_dump(1'b0, 0, 60, done_cycle, beats);
    checkOutput("dump1_done_cycle", 32'(done_cycle), 32'd33);
    checkOutput("dump1_beats", 32'(beats), 32'd32);

    $display("[TB] dump with toggling ready and a stray start");
    run_dump(1'b1, 20, 100, done_cycle, beats);
    checkOutput("dump2_done_cycle", 32'(done_cycle), 32'd64);
    checkOutput("dump2_beats", 32'(beats), 32'd32);
    done_seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      #1;
      if (o_dump_done || o_dump_busy) done_seen++;
    end
    checkOutput("dump2_no_retrigger", 32'(done_seen), 32'd0);

    $display("[TB] reset in the middle of a dump");
    found = 1'b0;
    @(negedge i_clk);
    i_dump_start = 1'b1;
    i_dump_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      i_dump_start = 1'b0;
      #1;
      if (o_dump_valid && o_dump_addr == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reached_addr10", 32'(found), 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(o_dump_valid), 32'd0);
    checkOutput("abort_busy", 32'(o_dump_busy), 32'd0);
    checkOutput("abort_done", 32'(o_dump_done), 32'd0);
    checkOutput("abort_addr", 32'(o_dump_addr), 32'd0);
    checkOutput("abort_data", o_dump_data, 32'd0);
    @(negedge i_clk);
    i_reset_n  = 1'b1;
    i_rd_addr1 = 5'd5;
    i_rd_addr2 = 5'd31;
    #1;
    checkOutput("post_reset_rd5", o_rd_data1, 32'd0);
    checkOutput("post_reset_rd31", o_rd_data2, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      #1;
      if (o_dump_done || o_dump_busy) done_seen++;
    end
    checkOutput("post_reset_no_done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
